// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer
// Description : Front-end fetch control. Drives the PC register load
//               (o_pc_next / o_pc_enable), issues single-outstanding imem
//               requests, registers returned instructions for decode,
//               honours hazard stalls and merges branch/jump redirects.
//               Optional macro FETCH_TIMEOUT_EN builds a WAIT watchdog that
//               raises a sticky o_timeout and retries the fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MAX_WAIT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_pc,
  input  logic        i_stall,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  output logic [31:0] o_pc_next,
  output logic        o_pc_enable,
  output logic        o_imem_req,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_instr,
  output logic [31:0] o_instr_pc,
  output logic        o_fetch_valid,
  output logic        o_timeout
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] redirect_target;
  logic [31:0] pc_inc;
  logic        capture;
  logic        drop;
  logic        set_pending;
  logic        pending_valid;
  logic [31:0] pending_pc;

  // Word-aligned redirect target and sequential next PC (wraps mod 2^32)
  assign redirect_target = i_redirect_pc & 32'hFFFF_FFFC;
  assign pc_inc          = i_pc + 32'd4;

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_hit;
  logic             timeout_flag;

  // Watchdog: restart on WAIT entry, count every cycle spent in WAIT
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wait_cnt <= '0;
    end else if (state != ST_WAIT && state_nxt == ST_WAIT) begin
      wait_cnt <= '0;
    end else if (state == ST_WAIT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Sticky timeout flag, cleared only by reset
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      timeout_flag <= 1'b0;
    end else if (timeout_hit) begin
      timeout_flag <= 1'b1;
    end
  end

  assign o_timeout = timeout_flag;
`else
  assign o_timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and combinational PC/request outputs
  always_comb begin
    state_nxt   = state;
    o_pc_next   = pc_inc;
    o_pc_enable = 1'b0;
    o_imem_req  = 1'b0;
    capture     = 1'b0;
    drop        = 1'b0;
    set_pending = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        o_pc_enable = 1'b1;
        o_pc_next   = RESET_PC;
        state_nxt   = ST_REQ;
      end
      ST_REQ: begin
        if (i_redirect_valid) begin
          o_pc_enable = 1'b1;
          o_pc_next   = redirect_target;
        end else if (!i_stall) begin
          o_imem_req = 1'b1;
          if (i_imem_gnt) begin
            state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (i_imem_rvalid) begin
          if (i_redirect_valid || pending_valid) begin
            // Instruction belongs to the squashed path: drop it
            drop        = 1'b1;
            o_pc_enable = 1'b1;
            o_pc_next   = i_redirect_valid ? redirect_target : pending_pc;
            state_nxt   = ST_REQ;
          end else begin
            capture = 1'b1;
            if (!i_stall) begin
              o_pc_enable = 1'b1;
              state_nxt   = ST_REQ;
            end else begin
              state_nxt = ST_HOLD;
            end
          end
        end else begin
          set_pending = i_redirect_valid;
`ifdef FETCH_TIMEOUT_EN
          if (wait_cnt == CNT_W'(MAX_WAIT - 1)) begin
            timeout_hit = 1'b1;
            state_nxt   = ST_REQ;
          end
`endif
        end
      end
      ST_HOLD: begin
        if (i_redirect_valid) begin
          o_pc_enable = 1'b1;
          o_pc_next   = redirect_target;
          state_nxt   = ST_REQ;
        end else if (!i_stall) begin
          o_pc_enable = 1'b1;
          state_nxt   = ST_REQ;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Decode-side instruction register; valid pulses on capture, holds in HOLD
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_instr       <= '0;
      o_instr_pc    <= '0;
      o_fetch_valid <= 1'b0;
    end else begin
      if (capture) begin
        o_instr    <= i_imem_rdata;
        o_instr_pc <= i_pc;
      end
      o_fetch_valid <= capture || (state == ST_HOLD && state_nxt == ST_HOLD);
    end
  end

  // Redirect seen while a fetch is in flight; latest target wins
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pending_valid <= 1'b0;
      pending_pc    <= '0;
    end else if (set_pending) begin
      pending_valid <= 1'b1;
      pending_pc    <= redirect_target;
    end else if (drop || (state == ST_REQ && i_redirect_valid)) begin
      pending_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_sequencer
// Description : Self-checking bench for fetch_sequencer. The bench acts as
//               PC register and imem, and compares the DUT each cycle with
//               a transaction-level reference model (directed + random).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          MAX_WAIT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = '0;
  logic        stall = 1'b0;
  logic        redir = 1'b0;
  logic [31:0] redir_pc = '0;
  logic        gnt = 1'b0;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = '0;
  logic [31:0] pc_next;
  logic        pc_enable;
  logic        imem_req;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        fetch_valid;
  logic        timeout;

  int checks = 0;
  int errors = 0;

  // Reference model: what the front end knows at transaction level
  bit          started;
  bit          busy;
  bit          hold;
  bit          pend_v;
  logic [31:0] pend_pc;
  logic [31:0] m_instr;
  logic [31:0] m_ipc;
  bit          m_fv;
  bit          m_to;
  int          wc;
  logic [31:0] saved_pc;

  fetch_sequencer #(
    .RESET_PC (RESET_PC),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_pc             (pc),
    .i_stall          (stall),
    .i_redirect_valid (redir),
    .i_redirect_pc    (redir_pc),
    .o_pc_next        (pc_next),
    .o_pc_enable      (pc_enable),
    .o_imem_req       (imem_req),
    .i_imem_gnt       (gnt),
    .i_imem_rvalid    (rvalid),
    .i_imem_rdata     (rdata),
    .o_instr          (instr),
    .o_instr_pc       (instr_pc),
    .o_fetch_valid    (fetch_valid),
    .o_timeout        (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    started = 0; busy = 0; hold = 0; pend_v = 0; pend_pc = '0;
    m_instr = '0; m_ipc = '0; m_fv = 0; m_to = 0; wc = 0;
  endtask

  // One clock: drive at negedge, check, then advance model and PC register
  task automatic cycle(input bit s, input bit r, input logic [31:0] rp,
                       input bit g, input bit rv, input logic [31:0] rd);
    logic [31:0] tgt, e_nx, s_nx, n_pend_pc, n_instr, n_ipc;
    bit e_en, e_req, s_en, n_started, n_busy, n_hold, n_pend_v, n_fv, n_to;
    int n_wc;
    @(negedge clk);
    stall = s; redir = r; redir_pc = rp; gnt = g; rvalid = rv; rdata = rd;
    #1;
    tgt = rp & 32'hFFFF_FFFC;
    e_nx = pc + 32'd4; e_en = 0; e_req = 0;
    n_started = started; n_busy = busy; n_hold = hold; n_pend_v = pend_v;
    n_pend_pc = pend_pc; n_instr = m_instr; n_ipc = m_ipc; n_fv = 0;
    n_to = m_to; n_wc = wc;
    if (!started) begin
      e_en = 1; e_nx = RESET_PC; n_started = 1;
    end else if (hold) begin
      if (r) begin e_en = 1; e_nx = tgt; n_hold = 0; end
      else if (!s) begin e_en = 1; n_hold = 0; end
      else n_fv = 1;
    end else if (busy) begin
      if (rv) begin
        n_busy = 0;
        if (r || pend_v) begin
          e_en = 1; e_nx = r ? tgt : pend_pc; n_pend_v = 0;
        end else begin
          n_instr = rd; n_ipc = pc; n_fv = 1;
          if (!s) e_en = 1; else n_hold = 1;
        end
      end else begin
        if (r) begin n_pend_v = 1; n_pend_pc = tgt; end
        n_wc = wc + 1;
`ifdef FETCH_TIMEOUT_EN
        if (n_wc == MAX_WAIT) begin n_busy = 0; n_to = 1; end
`endif
      end
    end else begin
      e_req = !s && !r;
      if (r) begin e_en = 1; e_nx = tgt; n_pend_v = 0; end
      if (e_req && g) begin n_busy = 1; n_wc = 0; end
    end
    chk("imem_req", imem_req, e_req);
    chk("pc_enable", pc_enable, e_en);
    chk("pc_next", pc_next, e_nx);
    chk("fetch_valid", fetch_valid, m_fv);
    if (m_fv) begin
      chk("instr", instr, m_instr);
      chk("instr_pc", instr_pc, m_ipc);
    end
    chk("timeout", timeout, m_to);
    s_en = pc_enable; s_nx = pc_next;
    @(posedge clk);
    #1;
    if (s_en) pc = s_nx;
    started = n_started; busy = n_busy; hold = n_hold; pend_v = n_pend_v;
    pend_pc = n_pend_pc; m_instr = n_instr; m_ipc = n_ipc; m_fv = n_fv;
    m_to = n_to; wc = n_wc;
  endtask

  initial begin
    bit s, r, g, rv;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_fetch_valid", fetch_valid, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_pc_enable", pc_enable, 1'b1);
    chk("rst_pc_next", pc_next, RESET_PC);
    chk("rst_imem_req", imem_req, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Straight-line fetches: PC 0,4,8,C with gnt immediate, rvalid next cycle
    cycle(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, 1, 0, 0);
      cycle(0, 0, 0, 0, 1, 32'hA000_0000 + i);
    end
    chk("seq_pc", pc, 32'h10);

    // Redirect during WAIT, data returns 3 cycles later and is dropped
    cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 1, 32'h103, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 32'hDEAD_BEEF);
    chk("redir_pc", pc, 32'h100);
    cycle(0, 0, 0, 1, 0, 0);

    // Return under stall: HOLD for 4 cycles, PC moves on release only
    cycle(1, 0, 0, 0, 1, 32'h1234_5678);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0, 0);
    chk("hold_pc", pc, 32'h100);
    cycle(0, 0, 0, 0, 0, 0);
    chk("release_pc", pc, 32'h104);

    // Sequential PC wraps at the top of the address space
    pc = 32'hFFFF_FFFC;
    cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 1, 32'h0BAD_F00D);
    chk("wrap_pc", pc, 32'h0);

    // Redirect and data in the same WAIT cycle
    cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 1, 32'h2222_2206, 0, 1, 32'h5555_5555);
    chk("same_cycle_redir_pc", pc, 32'h2222_2204);

    // Granted fetch with no data for MAX_WAIT cycles
    cycle(0, 0, 0, 1, 0, 0);
    saved_pc = pc;
    for (int i = 0; i < MAX_WAIT; i++) cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    chk("retry_pc", pc, saved_pc);
`ifdef FETCH_TIMEOUT_EN
    chk("timeout_sticky", timeout, 1'b1);
`else
    chk("timeout_tied", timeout, 1'b0);
`endif
    cycle(0, 0, 0, 0, 1, 32'h7777_0000);

    // Asynchronous reset mid-fetch, then a stray rvalid in IDLE and REQ
    cycle(0, 0, 0, 1, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_fetch_valid", fetch_valid, 1'b0);
    chk("midrst_imem_req", imem_req, 1'b0);
    chk("midrst_pc_enable", pc_enable, 1'b1);
    chk("midrst_pc_next", pc_next, RESET_PC);
    chk("midrst_timeout", timeout, 1'b0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    cycle(0, 0, 0, 0, 1, 32'h1111_1111);
    cycle(1, 0, 0, 0, 1, 32'h2222_2222);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      s  = ($urandom % 4) == 0;
      r  = ($urandom % 8) == 0;
      g  = ($urandom % 2) == 0;
      rv = busy ? (($urandom % 3) == 0) : (!hold && (($urandom % 16) == 0));
      cycle(s, r, $urandom, g, rv, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
